// File: rtl/bist_ram_pkg.sv
// Shared definitions for the March C- self-testing RAM: controller states,
// per-element operation table and the fail_elem encoding.
package bist_ram_pkg;

  localparam int FAIL_ELEM_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M0   = 3'd1,
    ST_M1   = 3'd2,
    ST_M2   = 3'd3,
    ST_M3   = 3'd4,
    ST_M4   = 3'd5,
    ST_M5   = 3'd6,
    ST_DONE = 3'd7
  } state_t;

  localparam logic [FAIL_ELEM_W-1:0] ELEM_M0 = 3'd0;
  localparam logic [FAIL_ELEM_W-1:0] ELEM_M1 = 3'd1;
  localparam logic [FAIL_ELEM_W-1:0] ELEM_M2 = 3'd2;
  localparam logic [FAIL_ELEM_W-1:0] ELEM_M3 = 3'd3;
  localparam logic [FAIL_ELEM_W-1:0] ELEM_M4 = 3'd4;
  localparam logic [FAIL_ELEM_W-1:0] ELEM_M5 = 3'd5;

  // What one March element does at each address: optional read-compare,
  // optional write, and the sweep direction.
  typedef struct packed {
    logic rd;
    logic rd_ones;
    logic wr;
    logic wr_ones;
    logic up;
  } elem_op_t;

  function automatic elem_op_t elem_op(input state_t s);
    elem_op_t op;
    op    = '0;
    op.up = 1'b1;
    case (s)
      ST_M0: op.wr = 1'b1;
      ST_M1: begin op.rd = 1'b1; op.wr = 1'b1; op.wr_ones = 1'b1; end
      ST_M2: begin op.rd = 1'b1; op.rd_ones = 1'b1; op.wr = 1'b1; end
      ST_M3: begin op.rd = 1'b1; op.wr = 1'b1; op.wr_ones = 1'b1; op.up = 1'b0; end
      ST_M4: begin op.rd = 1'b1; op.rd_ones = 1'b1; op.wr = 1'b1; op.up = 1'b0; end
      ST_M5: begin op.rd = 1'b1; op.up = 1'b0; end
      default: ;
    endcase
    return op;
  endfunction

  function automatic logic [FAIL_ELEM_W-1:0] elem_num(input state_t s);
    logic [FAIL_ELEM_W-1:0] n;
    n = ELEM_M0;
    case (s)
      ST_M1: n = ELEM_M1;
      ST_M2: n = ELEM_M2;
      ST_M3: n = ELEM_M3;
      ST_M4: n = ELEM_M4;
      ST_M5: n = ELEM_M5;
      default: n = ELEM_M0;
    endcase
    return n;
  endfunction

  function automatic state_t next_elem(input state_t s);
    state_t n;
    n = ST_IDLE;
    case (s)
      ST_M0: n = ST_M1;
      ST_M1: n = ST_M2;
      ST_M2: n = ST_M3;
      ST_M3: n = ST_M4;
      ST_M4: n = ST_M5;
      ST_M5: n = ST_DONE;
      default: n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bist_march_ctrl.sv
// March C- sequencer: walks the six elements one address per cycle, compares
// the combinational array read and records the first mismatch.
module bist_march_ctrl
  import bist_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [DATA_W-1:0]      rdata_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   fail_o,
  output logic [ADDR_W-1:0]      fail_addr_o,
  output logic [FAIL_ELEM_W-1:0] fail_elem_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic                   mem_we_o,
  output logic [DATA_W-1:0]      mem_wdata_o
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   fail_q, fail_d;
  logic [ADDR_W-1:0]      fail_addr_q, fail_addr_d;
  logic [FAIL_ELEM_W-1:0] fail_elem_q, fail_elem_d;

  elem_op_t          op;
  state_t            nxt_elem;
  elem_op_t          nxt_op;
  logic              busy;
  logic              accept;
  logic              mismatch;
  logic              last_addr;
  logic [DATA_W-1:0] exp_word;

  assign op        = elem_op(state_q);
  assign nxt_elem  = next_elem(state_q);
  assign nxt_op    = elem_op(nxt_elem);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign accept    = (state_q == ST_IDLE) && start_i;
  assign exp_word  = op.rd_ones ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  assign mismatch  = busy && op.rd && (rdata_i != exp_word);
  assign last_addr = op.up ? (addr_q == ADDR_MAX) : (addr_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      addr_q      <= addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_M0;
          addr_d      = '0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
        if (mismatch) begin
          // Only the first mismatch is recorded: the run ends right here.
          state_d     = ST_DONE;
          fail_d      = 1'b1;
          fail_addr_d = addr_q;
          fail_elem_d = elem_num(state_q);
        end else if (last_addr) begin
          state_d = nxt_elem;
          addr_d  = nxt_op.up ? '0 : ADDR_MAX;
        end else begin
          addr_d = op.up ? addr_q + 1'b1 : addr_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = busy;
    done_o      = (state_q == ST_DONE);
    mem_addr_o  = addr_q;
    mem_we_o    = busy && op.wr && !mismatch;
    mem_wdata_o = op.wr_ones ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;

endmodule

// File: rtl/bist_ram.sv
// Single-port RAM with combinational read and a built-in March C- self-test;
// the test controller takes over the array port while it runs.
module bist_ram
  import bist_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      data_in,
  output logic [DATA_W-1:0]      data_out,
  input  logic                   fault_inj,
  input  logic                   bist_start,
  output logic                   bist_busy,
  output logic                   bist_done,
  output logic                   bist_fail,
  output logic [ADDR_W-1:0]      fail_addr,
  output logic [FAIL_ELEM_W-1:0] fail_elem
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              busy;
  logic [ADDR_W-1:0] bist_addr;
  logic              bist_we;
  logic [DATA_W-1:0] bist_wdata;
  logic [ADDR_W-1:0] port_addr;
  logic              port_we;
  logic [DATA_W-1:0] port_wdata;
  logic [DATA_W-1:0] rd_word;

  bist_march_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (bist_start),
    .rdata_i     (rd_word),
    .busy_o      (busy),
    .done_o      (bist_done),
    .fail_o      (bist_fail),
    .fail_addr_o (fail_addr),
    .fail_elem_o (fail_elem),
    .mem_addr_o  (bist_addr),
    .mem_we_o    (bist_we),
    .mem_wdata_o (bist_wdata)
  );

  // The self-test owns the single array port while busy; functional
  // writes are dropped, not queued.
  assign port_addr  = busy ? bist_addr  : addr;
  assign port_we    = busy ? bist_we    : wr;
  assign port_wdata = busy ? bist_wdata : data_in;

  // Fault injection sits on the read path so the self-test sees it too.
  assign rd_word = mem_q[port_addr] | {{(DATA_W-1){1'b0}}, fault_inj};

  always_ff @(posedge clk) begin
    if (port_we) mem_q[port_addr] <= port_wdata;
  end

  assign data_out  = busy ? {DATA_W{1'b0}} : rd_word;
  assign bist_busy = busy;

endmodule
